arb_requester: RTL
==================

// Module: arb_requester
// PURPOSE
//  Requester-side front end for one port of the 4-way round-robin arbiter.
//  Buffers words from a local source in a FIFO and raises req while data is pending.
//  While gnt is high, it drains one word per cycle onto the shared bus.
//  When the fixed grant window closes, it re-requests if words remain.
//  One instance per master (req0..req3 / gnt0..gnt3).
// PARAMETERS
//  DW       8    data word width
//  AW       4    FIFO address width; depth = 2**AW = 16
//  TMO_W    6    request-timeout counter width; timeout after 2**TMO_W-1 = 63 cycles
// PORTS
//  clk      in   1       clock
//  resetl   in   1       reset; synchronous, active-low
//  wr_en    in   1       local push strobe
//  wr_data  in   DW      local push data
//  full     out  1       FIFO full (count == 2**AW)
//  count    out  AW+1    FIFO occupancy
//  req      out  1       request to arbiter
//  gnt      in   1       grant from arbiter (combinational from arbiter state)
//  bus_valid out 1       registered: bus_data holds a valid beat
//  bus_data out  DW      registered beat data
//  ovf      out  1       sticky: push attempted while full
//  tmo      out  1       sticky: req held 63 cycles with no gnt
//  gnt_err  out  1       sticky: gnt seen in IDLE (not requesting)
// BEHAVIOUR
//  Reset (resetl=0 at posedge): state=IDLE, FIFO empty.
//   All outputs are 0 except full=0 and count=0. Reset mid-grant discards FIFO contents.
//  FSM, one-hot, three states:
//   IDLE: req=0. If count!=0 -> REQ. If gnt=1 -> set gnt_err, no pop.
//   REQ:  req=1. Timeout counter increments each cycle while gnt=0.
//         Counter reaches 63 -> tmo=1; stay in REQ.
//         gnt=1 -> pop head if non-empty, go XFER, clear the timeout counter.
//   XFER: req=0 (the arbiter ignores req during a grant).
//         gnt=1 and FIFO non-empty -> pop one word.
//         gnt=1 and FIFO empty -> idle beat; stay in XFER.
//         gnt=0 -> REQ if post-update count!=0, else IDLE.
//  Pop path: a word popped in cycle t appears as bus_valid=1 / bus_data=word in cycle t+1.
//   bus_valid=0 in every cycle after a non-pop cycle. bus_data holds its last value when not valid.
//  An 8-cycle arbiter grant yields at most 8 beats. Remaining words cost one REQ round trip.
//  Push: wr_en=1 and full=0 writes wr_data. The word is poppable from the next cycle.
//  wr_en=1 while full=1: word dropped, ovf=1. This holds even if a pop occurs the same cycle.
//  Simultaneous push+pop when not full: count unchanged; both take effect.
//  Pointers wrap modulo 2**AW. count is AW+1 bits, so full and empty are unambiguous.
//  FIFO order is strict FIFO. No beat is duplicated or skipped across grant windows.
//  Sticky flags clear only on reset.
// STRUCTURE
//  Shared package (arb_pkg): one-hot state constants REQ_IDLE=3'b001, REQ_REQ=3'b010,
//   REQ_XFER=3'b100; GNT_WIN=8 (the arbiter's grant length, used by benches).
//  Sub-module sync_fifo #(DW,AW): push/pop/full/empty/count with push-while-full dropped.
//  Top level: FSM, timeout counter, registered bus output stage, sticky flags.
// TESTING
//  1 Push A1,A2,A3; gnt high 8 cycles after req
//     -> beats A1,A2,A3 on consecutive cycles starting 1 cycle after gnt rises,
//        then 5 idle cycles, then IDLE with req=0.
//  2 Push 12 words; first gnt window 8 cycles
//     -> 8 beats, req re-asserts the cycle after gnt falls;
//        second window -> remaining 4 beats in order, count=0.
//  3 Push 17 words back-to-back with no gnt
//     -> full=1 at count=16; 17th word dropped, ovf=1; later drain yields exactly 16 beats.
//  4 Push 1 word, hold gnt=0
//     -> tmo=1 on the 63rd REQ cycle; req stays 1; a later gnt still delivers the word.
//  5 Assert resetl=0 mid-grant after 3 beats
//     -> next cycle req=0, bus_valid=0, count=0, flags 0; gnt during IDLE then sets gnt_err=1.
//  6 Push during XFER, FIFO empty, gnt still high
//     -> word is popped the next cycle and appears on the bus within the same window.

Source files
------------

// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared requester state encoding and arbiter grant length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [2:0] {
        REQ_IDLE = 3'b001,
        REQ_REQ  = 3'b010,
        REQ_XFER = 3'b100
    } req_state_t;

    // Length of one arbiter grant window in cycles.
    localparam int GNT_WIN = 8;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO; a push while full is dropped even if a pop
//            happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
)(
    input  logic          clk,
    input  logic          resetl,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_pop_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(1 << AW);

    logic [DW-1:0] r_mem [0:(1 << AW)-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full     = (r_count == c_DEPTH);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!resetl) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/arb_requester.sv
// ============================================================================
// Module   : arb_requester
// Brief    : Requester front end for one round-robin arbiter port: buffers
//            local words, requests the bus and drains one beat per granted cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_requester
    import arb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int TMO_W = 6
)(
    input  logic          clk,
    input  logic          resetl,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic [AW:0]   count,
    output logic          req,
    input  logic          gnt,
    output logic          bus_valid,
    output logic [DW-1:0] bus_data,
    output logic          ovf,
    output logic          tmo,
    output logic          gnt_err
);

    localparam logic [TMO_W-1:0] c_TMO_MAX  = TMO_W'((1 << TMO_W) - 1);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'((1 << TMO_W) - 2);

    req_state_t       r_state;
    req_state_t       w_state_next;
    logic             w_req;
    logic             w_pop;
    logic             w_set_gnt_err;
    logic             w_push_ok;
    logic             w_empty;
    logic [DW-1:0]    w_fifo_dout;
    logic [AW:0]      w_count_next;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_bus_valid;
    logic [DW-1:0]    r_bus_data;
    logic             r_ovf;
    logic             r_tmo;
    logic             r_gnt_err;

    sync_fifo #(
        .DW (DW),
        .AW (AW)
    ) u_fifo (
        .clk         (clk),
        .resetl      (resetl),
        .i_push      (wr_en),
        .i_push_data (wr_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_dout),
        .o_full      (full),
        .o_empty     (w_empty),
        .o_count     (count)
    );

    assign w_push_ok = wr_en && !full;
    // Occupancy after this cycle when no pop is taking place.
    assign w_count_next = count + (AW+1)'(w_push_ok);

    always_ff @(posedge clk) begin
        if (!resetl) r_state <= REQ_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_req         = 1'b0;
        w_pop         = 1'b0;
        w_set_gnt_err = 1'b0;
        case (r_state)
            REQ_IDLE: begin
                if (gnt)           w_set_gnt_err = 1'b1;
                if (count != '0)   w_state_next  = REQ_REQ;
            end
            REQ_REQ: begin
                w_req = 1'b1;
                if (gnt) begin
                    w_pop        = !w_empty;
                    w_state_next = REQ_XFER;
                end
            end
            REQ_XFER: begin
                if (gnt)                      w_pop        = !w_empty;
                else if (w_count_next != '0)  w_state_next = REQ_REQ;
                else                          w_state_next = REQ_IDLE;
            end
            default: w_state_next = REQ_IDLE;
        endcase
    end

    // Timeout counter saturates so the sticky flag sets exactly once.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else if (r_state == REQ_REQ && !gnt) begin
            if (r_tmo_cnt != c_TMO_MAX)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (r_tmo_cnt == c_TMO_LAST) r_tmo     <= 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_ovf       <= 1'b0;
            r_gnt_err   <= 1'b0;
        end else begin
            r_bus_valid <= w_pop;
            if (w_pop)         r_bus_data <= w_fifo_dout;
            if (wr_en && full) r_ovf      <= 1'b1;
            if (w_set_gnt_err) r_gnt_err  <= 1'b1;
        end
    end

    assign req       = w_req;
    assign bus_valid = r_bus_valid;
    assign bus_data  = r_bus_data;
    assign ovf       = r_ovf;
    assign tmo       = r_tmo;
    assign gnt_err   = r_gnt_err;

endmodule

`default_nettype wire
